// File: rtl/sb_regfile.sv
// Scoreboarded integer register file: NRD combinational read ports with
// write bypass, NWR writeback ports, and per-register pending-write counters.
module sb_regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2,
    parameter int unsigned PW   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NRD*$clog2(NREG)-1:0]   rs_addr,
    output logic [NRD-1:0]                rs_valid,
    output logic [NRD*XLEN-1:0]           rs_data,
    input  logic [$clog2(NREG)-1:0]       rd,
    input  logic                          reserve,
    output logic                          reserve_ok,
    input  logic [NWR*$clog2(NREG)-1:0]   wreg,
    input  logic [NWR*XLEN-1:0]           wdata,
    input  logic [NWR-1:0]                wen,
    input  logic                          flush,
    output logic                          busy
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned HW = $clog2(NWR + 1);
    localparam int unsigned CW = PW + HW + 1;
    localparam logic [PW-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] regs_q    [NREG];
    logic [XLEN-1:0] regs_d    [NREG];
    logic [PW-1:0]   cnt_q     [NREG];
    logic [PW-1:0]   cnt_d     [NREG];
    logic            busy_q;
    logic            busy_d;

    logic [HW-1:0]   hit_cnt   [NREG];
    logic [XLEN-1:0] wsel_data [NREG];
    logic [AW-1:0]   wr_a;
    logic [AW-1:0]   rd_a;
    logic            res_r;
    logic [CW-1:0]   up_r;

    // Per-register write hit count and winning (highest-index) write data
    always_comb begin
        wr_a = '0;
        for (int r = 0; r < NREG; r++) begin
            hit_cnt[r]   = '0;
            wsel_data[r] = regs_q[r];
            for (int j = 0; j < NWR; j++) begin
                wr_a = wreg[j*AW +: AW];
                if (wen[j] && (wr_a != '0) && (wr_a == AW'(r))) begin
                    hit_cnt[r]   = hit_cnt[r] + HW'(1);
                    wsel_data[r] = wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // A full counter still accepts a reservation when a write retires it this cycle
    assign reserve_ok = (rd == '0) || flush || (cnt_q[rd] != CNT_MAX) || (hit_cnt[rd] != '0);

    always_comb begin
        busy_d = 1'b0;
        res_r  = 1'b0;
        up_r   = '0;
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = wsel_data[r];
            cnt_d[r]  = '0;
        end
        regs_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            res_r = reserve && reserve_ok && !flush && (rd == AW'(r));
            up_r  = CW'(cnt_q[r]) + CW'(res_r);
            if (flush) begin
                cnt_d[r] = '0;
            end else if (up_r > CW'(hit_cnt[r])) begin
                cnt_d[r] = PW'(up_r - CW'(hit_cnt[r]));
            end else begin
                cnt_d[r] = '0;
            end
            busy_d = busy_d || (cnt_d[r] != '0);
        end
    end

    // Operand read with same-cycle writeback bypass
    always_comb begin
        rs_valid = '1;
        rs_data  = '0;
        rd_a     = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_a = rs_addr[i*AW +: AW];
            if (rd_a != '0) begin
                rs_data[i*XLEN +: XLEN] = wsel_data[rd_a];
                rs_valid[i]             = (CW'(cnt_q[rd_a]) <= CW'(hit_cnt[rd_a]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            busy_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n) begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (wreg[j*AW +: AW] != '0)) begin
                    $display("[%0t] sb_regfile wb port %0d x%0d = 0x%08h",
                             $time, j, wreg[j*AW +: AW], wdata[j*XLEN +: XLEN]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sb_regfile.sv
// Self-checking bench for sb_regfile: directed scenarios plus randomized
// traffic compared against an array-based model of the scoreboard rules.
module tb_sb_regfile;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int PW   = 2;
    localparam int AW   = 5;
    localparam int CMAX = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NRD*AW-1:0]    rs_addr;
    logic [NRD-1:0]       rs_valid;
    logic [NRD*XLEN-1:0]  rs_data;
    logic [AW-1:0]        rd;
    logic                 reserve;
    logic                 reserve_ok;
    logic [NWR*AW-1:0]    wreg;
    logic [NWR*XLEN-1:0]  wdata;
    logic [NWR-1:0]       wen;
    logic                 flush;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0] m_regs [NREG];
    int              m_cnt  [NREG];
    logic [NRD-1:0]  e_valid;
    logic [XLEN-1:0] e_data [NRD];
    logic            e_ok;
    logic            e_busy;

    sb_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .PW(PW)) dut (
        .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rs_valid(rs_valid),
        .rs_data(rs_data), .rd(rd), .reserve(reserve), .reserve_ok(reserve_ok),
        .wreg(wreg), .wdata(wdata), .wen(wen), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        reset_n = 1'b1; rs_addr = '0; rd = '0; reserve = 1'b0;
        wreg = '0; wdata = '0; wen = '0; flush = 1'b0;
    endtask

    task automatic set_rs(input int i, input int a);
        rs_addr[i*AW +: AW] = 5'(a);
    endtask

    task automatic set_wr(input int j, input bit en, input int r, input logic [XLEN-1:0] d);
        wen[j] = en;
        wreg[j*AW +: AW] = 5'(r);
        wdata[j*XLEN +: XLEN] = d;
    endtask

    function automatic int hits_of(input int r);
        int h = 0;
        for (int j = 0; j < NWR; j++)
            if (wen[j] && wreg[j*AW +: AW] != 0 && int'(wreg[j*AW +: AW]) == r) h++;
        return h;
    endfunction

    function automatic logic [XLEN-1:0] wval_of(input int r);
        logic [XLEN-1:0] v = m_regs[r];
        for (int j = 0; j < NWR; j++)
            if (wen[j] && wreg[j*AW +: AW] != 0 && int'(wreg[j*AW +: AW]) == r)
                v = wdata[j*XLEN +: XLEN];
        return v;
    endfunction

    // Expected combinational outputs from the model state and current inputs
    task automatic model_eval();
        int a;
        e_ok = (rd == 0) || flush || !(m_cnt[rd] == CMAX && hits_of(int'(rd)) == 0);
        e_busy = 1'b0;
        for (int r = 1; r < NREG; r++) if (m_cnt[r] != 0) e_busy = 1'b1;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rs_addr[i*AW +: AW]);
            if (a == 0) begin
                e_data[i] = '0; e_valid[i] = 1'b1;
            end else begin
                e_data[i]  = (hits_of(a) > 0) ? wval_of(a) : m_regs[a];
                e_valid[i] = (m_cnt[a] - hits_of(a) <= 0);
            end
        end
    endtask

    task automatic model_update();
        int h;
        int n;
        model_eval();
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                h = hits_of(r);
                if (h > 0) m_regs[r] = wval_of(r);
                if (flush) m_cnt[r] = 0;
                else begin
                    n = m_cnt[r] + ((reserve && e_ok && int'(rd) == r) ? 1 : 0) - h;
                    m_cnt[r] = (n < 0) ? 0 : n;
                end
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_rs(0, 5); set_rs(1, 0); rd = 5'd5;
        #1;
        n_cmp++; if (rs_data !== '0)      begin n_err++; $display("FAIL reset_data got %h want 0", rs_data); end
        n_cmp++; if (rs_valid !== 2'b11)  begin n_err++; $display("FAIL reset_valid got %b want 11", rs_valid); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (reserve_ok !== 1'b1) begin n_err++; $display("FAIL reset_ok got %b want 1", reserve_ok); end
        // Write and reserve x2, then reset with a concurrent write: nothing survives
        reserve = 1'b1; rd = 5'd2; set_wr(0, 1, 2, 32'h1234_5678);
        tick();
        reserve = 1'b1; reset_n = 1'b0; set_wr(1, 1, 2, 32'hCAFE_F00D);
        tick();
        set_idle(); set_rs(0, 2); set_rs(1, 2);
        #1;
        n_cmp++; if (rs_data !== '0)     begin n_err++; $display("FAIL midreset_data got %h want 0", rs_data); end
        n_cmp++; if (rs_valid !== 2'b11) begin n_err++; $display("FAIL midreset_valid got %b want 11", rs_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL midreset_busy got %b want 0", busy); end
    endtask

    task automatic test_reserve_write();
        do_reset();
        reserve = 1'b1; rd = 5'd5; set_rs(0, 5);
        #1;
        n_cmp++; if (reserve_ok !== 1'b1) begin n_err++; $display("FAIL rsv_ok got %b want 1", reserve_ok); end
        n_cmp++; if (rs_valid[0] !== 1'b1) begin n_err++; $display("FAIL rsv_same_cycle_valid got %b want 1", rs_valid[0]); end
        tick();
        reserve = 1'b0;
        #1;
        n_cmp++; if (rs_valid[0] !== 1'b0) begin n_err++; $display("FAIL rsv_pending_valid got %b want 0", rs_valid[0]); end
        n_cmp++; if (busy !== 1'b1)        begin n_err++; $display("FAIL rsv_busy got %b want 1", busy); end
        tick();
        set_wr(0, 1, 5, 32'hDEAD_BEEF);
        #1;
        n_cmp++; if (rs_data[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bypass_data got %h want deadbeef", rs_data[31:0]); end
        n_cmp++; if (rs_valid[0] !== 1'b1) begin n_err++; $display("FAIL bypass_valid got %b want 1", rs_valid[0]); end
        tick();
        wen = '0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL retire_busy got %b want 0", busy); end
        n_cmp++; if (rs_data[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL stored_data got %h want deadbeef", rs_data[31:0]); end
    endtask

    task automatic test_saturate();
        do_reset();
        reserve = 1'b1; rd = 5'd7; set_rs(0, 7);
        for (int k = 0; k < CMAX; k++) begin
            #1;
            n_cmp++; if (reserve_ok !== 1'b1) begin n_err++; $display("FAIL sat_ok%0d got %b want 1", k, reserve_ok); end
            tick();
        end
        #1;
        n_cmp++; if (reserve_ok !== 1'b0) begin n_err++; $display("FAIL sat_full got %b want 0", reserve_ok); end
        tick();
        #1;
        n_cmp++; if (reserve_ok !== 1'b0) begin n_err++; $display("FAIL sat_hold got %b want 0", reserve_ok); end
        set_wr(1, 1, 7, 32'h0000_0077);
        #1;
        n_cmp++; if (reserve_ok !== 1'b1) begin n_err++; $display("FAIL sat_write_ok got %b want 1", reserve_ok); end
        n_cmp++; if (rs_valid[0] !== 1'b0) begin n_err++; $display("FAIL sat_write_valid got %b want 0", rs_valid[0]); end
        tick();
        wen = '0;
        #1;
        n_cmp++; if (reserve_ok !== 1'b0) begin n_err++; $display("FAIL sat_after_got %b want 0", reserve_ok); end
    endtask

    task automatic test_dual_write();
        do_reset();
        reserve = 1'b1; rd = 5'd9;
        tick(); tick();
        reserve = 1'b0; set_rs(0, 9); set_rs(1, 9);
        set_wr(0, 1, 9, 32'h1111_1111); set_wr(1, 1, 9, 32'h2222_2222);
        #1;
        n_cmp++; if (rs_data[31:0] !== 32'h2222_2222) begin n_err++; $display("FAIL dual_data got %h want 22222222", rs_data[31:0]); end
        n_cmp++; if (rs_valid !== 2'b11) begin n_err++; $display("FAIL dual_valid got %b want 11", rs_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dual_busy_pre got %b want 1", busy); end
        tick();
        wen = '0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dual_busy_post got %b want 0", busy); end
        n_cmp++; if (rs_data[63:32] !== 32'h2222_2222) begin n_err++; $display("FAIL dual_stored got %h want 22222222", rs_data[63:32]); end
    endtask

    task automatic test_flush();
        do_reset();
        reserve = 1'b1; rd = 5'd3; tick();
        rd = 5'd4; tick();
        rd = 5'd6; flush = 1'b1;
        #1;
        n_cmp++; if (reserve_ok !== 1'b1) begin n_err++; $display("FAIL flush_ok got %b want 1", reserve_ok); end
        tick();
        set_idle(); set_rs(0, 6); set_rs(1, 3);
        #1;
        n_cmp++; if (rs_valid !== 2'b11) begin n_err++; $display("FAIL flush_valid got %b want 11", rs_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
        set_rs(1, 4);
        #1;
        n_cmp++; if (rs_valid[1] !== 1'b1) begin n_err++; $display("FAIL flush_x4 got %b want 1", rs_valid[1]); end
    endtask

    task automatic test_x0();
        do_reset();
        reserve = 1'b1; rd = 5'd4; tick();
        rd = 5'd0; set_wr(0, 1, 0, 32'hFFFF_FFFF); set_rs(0, 0); set_rs(1, 0);
        #1;
        n_cmp++; if (rs_data !== '0) begin n_err++; $display("FAIL x0_data got %h want 0", rs_data); end
        n_cmp++; if (rs_valid !== 2'b11) begin n_err++; $display("FAIL x0_valid got %b want 11", rs_valid); end
        n_cmp++; if (reserve_ok !== 1'b1) begin n_err++; $display("FAIL x0_ok got %b want 1", reserve_ok); end
        tick();
        set_idle(); set_rs(0, 0);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL x0_busy got %b want 1", busy); end
        n_cmp++; if (rs_data[31:0] !== '0) begin n_err++; $display("FAIL x0_after got %h want 0", rs_data[31:0]); end
    endtask

    // Randomized traffic on a narrow register window to force collisions
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom_range(0, 60) != 0);
            flush   = ($urandom_range(0, 25) == 0);
            reserve = $urandom_range(0, 1) != 0;
            rd      = 5'($urandom_range(0, 7));
            for (int i = 0; i < NRD; i++) set_rs(i, $urandom_range(0, 7));
            for (int j = 0; j < NWR; j++)
                set_wr(j, $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom);
            #1;
            model_eval();
            n_cmp++; if (reserve_ok !== e_ok) begin n_err++; $display("FAIL rnd_ok c=%0d got %b want %b", c, reserve_ok, e_ok); end
            n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, e_busy); end
            for (int i = 0; i < NRD; i++) begin
                n_cmp++; if (rs_valid[i] !== e_valid[i]) begin n_err++; $display("FAIL rnd_valid c=%0d p=%0d got %b want %b", c, i, rs_valid[i], e_valid[i]); end
                n_cmp++; if (rs_data[i*XLEN +: XLEN] !== e_data[i]) begin n_err++; $display("FAIL rnd_data c=%0d p=%0d got %h want %h", c, i, rs_data[i*XLEN +: XLEN], e_data[i]); end
            end
            tick();
        end
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
        set_idle();
        @(negedge clk);
        test_reset();
        test_reserve_write();
        test_saturate();
        test_dual_write();
        test_flush();
        test_x0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sb_regfile.md
# sb_regfile

Parametrised, scoreboarded integer register file for the core pipeline: multiple read ports, multiple writeback ports, and a per-register pending-write counter replacing a single valid bit. Decode reserves the destination and reads operands with readiness. Execute/memory writeback ports retire results with same-cycle bypass. Flush drops all outstanding reservations on a pipeline redirect.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers; register 0 hardwired to zero; AW = $clog2(NREG)
- NRD, 2, read ports
- NWR, 2, write ports; higher index = higher priority
- PW, 2, pending-counter width; max outstanding writers per register = 2^PW-1

Ports:
- clk  in  1  clock
- reset_n  in  1  reset_n, synchronous, active-low
- rs_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rs_valid  out  NRD  operand ready per port
- rs_data  out  NRD*XLEN  operand data per port
- rd  in  AW  destination to reserve
- reserve  in  1  reservation request for rd
- reserve_ok  out  1  reservation accepted this cycle
- wreg  in  NWR*AW  writeback addresses
- wdata  in  NWR*XLEN  writeback data
- wen  in  NWR  writeback enables
- flush  in  1  clear all pending counters
- busy  out  1  any pending counter nonzero

## Operation
- State: regs[1..NREG-1] (XLEN each), cnt[1..NREG-1] (PW each). Register 0 has no storage.
- Write hit: wen[j] and wreg[j]!=0. For register r, hits(r) = number of write ports hitting r this cycle. wsel(r) = highest-index port hitting r.
- Data update: regs[r] <= wdata[wsel(r)] when hits(r)>0.
- Counter update: cnt[r] <= sat0(cnt[r] + res(r) - hits(r)).
  - res(r) = 1 when reserve & reserve_ok & rd==r & rd!=0 & !flush.
  - sat0 clamps at 0. Extra writes on a zero counter are legal (no reservation) and leave it at 0.
- reserve_ok (combinational):
  - 1 when rd==0 or flush;
  - else 0 iff cnt[rd]==2^PW-1 and hits(rd)==0.
  - reserve with reserve_ok=0 is ignored; requester must hold and retry.
- Read port i, address a:
  - a==0: data 0, valid 1.
  - Else data = hits(a)>0 ? wdata[wsel(a)] : regs[a] (bypass).
  - valid = (sat0(cnt[a] - hits(a)) == 0). Same-cycle reservation does not affect valid.
- flush: all cnt <= 0 next edge. Same-cycle writes still update regs. Same-cycle reserve is discarded.
- busy = OR of all cnt != 0 (registered state only, no bypass).
- Reset (reset_n=0 at edge): all regs <= 0, all cnt <= 0. Writes, reserves and flush in that cycle are ignored.
- Simulation-only ($display under `ifndef SYNTHESIS`): one trace line per accepted write: time, port, register number, data.

## Timing
- Reads fully combinational from state plus same-cycle write inputs: 0-cycle latency, write-to-read bypass in the same cycle.
- Reservation visible on rs_valid from the cycle after reserve_ok=1.
- Write clears readiness in the same cycle via bypass: cnt=1 plus write to r gives valid=1 that cycle and cnt=0 next.
- Reserve and write to the same register in the same cycle: net counter unchanged when hits=1.
- Outputs after reset: rs_valid all 1, rs_data all 0, reserve_ok 1, busy 0.
- Reset mid-operation discards all pending state; no write survives.

## Test plan
- Reset, then read x5 and x0 on both ports -> data 0, valid 1, busy 0.
- Reserve x5 in cycle 1 -> cycle 2: rs_valid for x5 = 0, busy=1. In cycle 3 write x5=0xDEADBEEF on port 0 -> same cycle data 0xDEADBEEF, valid 1. Cycle 4: busy=0.
- Reserve x7 three times (PW=2) -> reserve_ok=0 on the fourth attempt and counter stays 3. Same fourth cycle with port 1 writing x7 -> reserve_ok=1 and counter stays 3.
- Ports 0 and 1 both write x9 (0x11111111 vs 0x22222222) with cnt[x9]=2 -> read returns 0x22222222, valid 1; cnt[x9]=0 next cycle.
- Reserve x3 and x4, then flush with a concurrent reserve of x6 -> next cycle all valid, busy=0, x6 not pending.
- Write x0=0xFFFFFFFF and reserve x0 -> x0 reads 0, valid 1, reserve_ok=1, busy unchanged.
